rr_mux_nbit: RTL and testbench



---
 rtl/mux_pkg.sv | 21 ++
 rtl/rr_mux_nbit_arbiter.sv | 37 +++
 rtl/rr_mux_nbit.sv | 120 ++++++++++++
 tb/tb_rr_mux_nbit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin N-bit multiplexer: index-width helper
// and the arbitration mode encoding.
package mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Bits needed to index 'value' channels; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage : mux_pkg

// File: rtl/rr_mux_nbit_arbiter.sv
// Combinational M-way arbiter: round-robin search starting at ptr_i, or
// fixed priority with channel 0 highest. Produces a one-hot grant plus its index.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0]          req_i,
    input  logic [clog2(M)-1:0]   ptr_i,
    input  logic                  mode_i,
    output logic [M-1:0]          grant_o,
    output logic [clog2(M)-1:0]   idx_o,
    output logic                  any_o
);

    localparam int SELW = clog2(M);

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path through the loop can infer a latch.
    always_comb begin
        int  cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < M; k++) begin
            // Visit channels in priority order; ptr_i is always below M.
            cand = (mode_i == MODE_FIXED) ? k : (int'(ptr_i) + k) % M;
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = SELW'(cand);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/rr_mux_nbit.sv
// Registered round-robin M-to-1 mux with valid/ready on every channel.
// Optional burst lock (input lock_i) is built when RRMUX_LOCK_EN is defined.
module rr_mux_nbit
    import mux_pkg::*;
#(
    parameter int N = 64,
    parameter int M = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode_i,
    input  logic [M-1:0]          in_valid_i,
    input  logic [M*N-1:0]        in_data_i,
`ifdef RRMUX_LOCK_EN
    input  logic                  lock_i,
`endif
    output logic [M-1:0]          in_ready_o,
    output logic                  out_valid_o,
    output logic [N-1:0]          out_data_o,
    output logic [clog2(M)-1:0]   out_sel_o,
    input  logic                  out_ready_i
);

    localparam int SELW = clog2(M);

    logic [SELW-1:0] ptr_q,       ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0] out_sel_q,   out_sel_d;

    logic [M-1:0]    req_eff;
    logic [M-1:0]    grant;
    logic [SELW-1:0] grant_idx;
    logic            any_grant;
    logic            load_en;
    logic            xfer;
    logic [SELW-1:0] ptr_inc;

`ifdef RRMUX_LOCK_EN
    logic lock_q, lock_d;
    logic lock_hold;

    // A held lock narrows the request set to the locked channel while it stays valid.
    assign lock_hold = lock_q && in_valid_i[ptr_q];
    assign req_eff   = lock_hold ? (M'(1) << ptr_q) : in_valid_i;
`else
    assign req_eff   = in_valid_i;
`endif

    rr_arbiter #(
        .M (M)
    ) u_arbiter (
        .req_i   (req_eff),
        .ptr_i   (ptr_q),
        .mode_i  (mode_i),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (any_grant)
    );

    assign load_en    = !out_valid_q || out_ready_i;
    assign xfer       = load_en && any_grant && !reset;
    assign in_ready_o = (load_en && !reset) ? grant : '0;
    assign ptr_inc    = (grant_idx == SELW'(M - 1)) ? '0 : grant_idx + SELW'(1);

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifdef RRMUX_LOCK_EN
        lock_d      = lock_q;
        if (lock_q && !in_valid_i[ptr_q]) begin
            lock_d = 1'b0;
        end
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data_i[grant_idx*N +: N];
            out_sel_d   = grant_idx;
            ptr_d       = ptr_inc;
`ifdef RRMUX_LOCK_EN
            // A locking beat parks the pointer on its own channel.
            if (lock_i) begin
                ptr_d = grant_idx;
            end
            lock_d = lock_i;
`endif
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking '<='; the data register is reset
    // too, since out_data must read zero out of reset rather than stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef RRMUX_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef RRMUX_LOCK_EN
            lock_q      <= lock_d;
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sel_o   = out_sel_q;

endmodule : rr_mux_nbit

// File: tb/tb_rr_mux_nbit.sv
// Self-checking bench for rr_mux_nbit: directed vector table, hand sequences
// for backpressure and lock bursts, and randomized traffic against a reference model.
module tb_rr_mux_nbit;

    localparam int N = 64;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           mode;
    logic [M-1:0]   in_valid;
    logic [M*N-1:0] in_data;
    logic [M-1:0]   in_ready;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_ready;
    logic           lock;

    always #5 clk = ~clk;

    rr_mux_nbit #(.N(N), .M(M)) dut (
        .clk         (clk),
        .reset       (reset),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
`ifdef RRMUX_LOCK_EN
        .lock_i      (lock),
`endif
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_sel_o   (out_sel),
        .out_ready_i (out_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: the held beat, the priority pointer, the lock flag.
    bit           m_valid = 1'b0;
    logic [N-1:0] m_data  = '0;
    int           m_sel   = 0;
    int           m_ptr   = 0;
    bit           m_lock  = 1'b0;
    int           m_win   = -1;
    bit           m_load  = 1'b0;
    logic [M-1:0] m_rdy   = '0;

    typedef struct {
        bit         rst;
        bit         md;
        logic [3:0] iv;
        bit         ordy;
        logic [3:0] rdy;
        bit         ov;
        int         sel;
    } vec_t;

    vec_t tbl [26];

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick_winner();
        int c;
        if (m_lock && in_valid[m_ptr]) return m_ptr;
        for (int k = 0; k < M; k++) begin
            c = mode ? k : (m_ptr + k) % M;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_comb();
        m_win  = pick_winner();
        m_load = !m_valid || out_ready;
        m_rdy  = '0;
        if (!reset && m_load && m_win >= 0) m_rdy[m_win] = 1'b1;
    endtask

    task automatic model_update();
        if (reset) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 0;
            m_lock  = 1'b0;
        end else begin
            if (m_lock && !in_valid[m_ptr]) m_lock = 1'b0;
            if (m_load && m_win >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[m_win*N +: N];
                m_sel   = m_win;
                m_ptr   = lock ? m_win : (m_win + 1) % M;
                m_lock  = lock;
            end else if (m_load) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic settle();
        #2;
        model_comb();
        check("model_in_ready",  N'(in_ready),  N'(m_rdy));
        check("model_out_valid", N'(out_valid), N'(m_valid));
        check("model_out_data",  out_data,      m_data);
        check("model_out_sel",   N'(out_sel),   N'(m_sel));
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic std_data();
        for (int i = 0; i < M; i++) in_data[i*N +: N] = N'(64'hA0 + i);
    endtask

    initial begin
        //          rst md  iv     ordy rdy    ov sel
        tbl[0]  = '{1, 0, 4'hF, 1, 4'h0, 0, 0};
        tbl[1]  = '{0, 0, 4'hF, 1, 4'h1, 0, 0};
        tbl[2]  = '{0, 0, 4'hF, 1, 4'h2, 1, 0};
        tbl[3]  = '{0, 0, 4'hF, 1, 4'h4, 1, 1};
        tbl[4]  = '{0, 0, 4'hF, 1, 4'h8, 1, 2};
        tbl[5]  = '{0, 0, 4'hF, 1, 4'h1, 1, 3};
        tbl[6]  = '{0, 0, 4'hF, 1, 4'h2, 1, 0};
        tbl[7]  = '{0, 1, 4'hA, 1, 4'h2, 1, 1};
        tbl[8]  = '{0, 1, 4'hA, 1, 4'h2, 1, 1};
        tbl[9]  = '{0, 1, 4'hA, 1, 4'h2, 1, 1};
        tbl[10] = '{0, 1, 4'h8, 1, 4'h8, 1, 1};
        tbl[11] = '{0, 0, 4'h0, 1, 4'h0, 1, 3};
        tbl[12] = '{0, 0, 4'h0, 1, 4'h0, 0, 3};
        tbl[13] = '{0, 0, 4'h4, 1, 4'h4, 0, 3};
        tbl[14] = '{0, 0, 4'h2, 1, 4'h2, 1, 2};
        tbl[15] = '{0, 0, 4'hF, 1, 4'h4, 1, 1};
        tbl[16] = '{0, 0, 4'hF, 0, 4'h0, 1, 2};
        tbl[17] = '{0, 0, 4'hF, 0, 4'h0, 1, 2};
        tbl[18] = '{0, 0, 4'hF, 0, 4'h0, 1, 2};
        tbl[19] = '{0, 0, 4'hF, 1, 4'h8, 1, 2};
        tbl[20] = '{0, 0, 4'h0, 0, 4'h0, 1, 3};
        tbl[21] = '{0, 0, 4'h0, 1, 4'h0, 1, 3};
        tbl[22] = '{0, 0, 4'h0, 0, 4'h0, 0, 3};
        tbl[23] = '{0, 0, 4'hF, 0, 4'h1, 0, 3};
        tbl[24] = '{1, 0, 4'hF, 0, 4'h0, 1, 0};
        tbl[25] = '{0, 0, 4'hF, 1, 4'h1, 0, 0};

        reset     = 1'b1;
        mode      = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b0;
        lock      = 1'b0;
        std_data();
        advance();

        // Directed table: expected values derived by hand from the operating rules.
        for (int i = 0; i < 26; i++) begin
            reset     = tbl[i].rst;
            mode      = tbl[i].md;
            in_valid  = tbl[i].iv;
            out_ready = tbl[i].ordy;
            settle();
            check($sformatf("tbl%0d_rdy", i), N'(in_ready),  N'(tbl[i].rdy));
            check($sformatf("tbl%0d_ov",  i), N'(out_valid), N'(tbl[i].ov));
            check($sformatf("tbl%0d_sel", i), N'(out_sel),   N'(tbl[i].sel));
            if (tbl[i].ov) check($sformatf("tbl%0d_data", i), out_data, N'(64'hA0 + tbl[i].sel));
            advance();
        end

        // Backpressure: hold 0xDEAD from channel 2 for three stalled cycles.
        in_data[2*N +: N] = N'(64'hDEAD);
        in_valid  = 4'h4;
        out_ready = 1'b1;
        settle();
        advance();
        in_valid  = 4'hF;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("bp%0d_data", c),  out_data,   N'(64'hDEAD));
            check($sformatf("bp%0d_ready", c), N'(in_ready), N'(0));
            advance();
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_ready", N'(in_ready), N'(4'h8));
        advance();
        settle();
        check("bp_next_sel", N'(out_sel), N'(3));
        advance();
        std_data();

`ifdef RRMUX_LOCK_EN
        // Lock burst: steer ptr to 2, then channel 2 sends lock=1,1,1,0.
        reset    = 1'b1;
        advance();
        reset    = 1'b0;
        in_valid = 4'h2;
        settle();
        advance();
        in_valid = 4'hD;
        for (int b = 0; b < 4; b++) begin
            lock = (b < 3);
            settle();
            check($sformatf("lock%0d_ready", b), N'(in_ready), N'(4'h4));
            advance();
            settle();
            check($sformatf("lock%0d_sel", b), N'(out_sel), N'(2));
        end
        lock = 1'b0;
        check("lock_after_ready", N'(in_ready), N'(4'h8));
        advance();
`endif

        // Randomized traffic against the reference model.
        for (int t = 0; t < 3000; t++) begin
            reset     = ($urandom_range(0, 63) == 0);
            mode      = ($urandom_range(0, 3) == 0);
            in_valid  = M'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < M; i++) in_data[i*N +: N] = {$urandom, $urandom};
`ifdef RRMUX_LOCK_EN
            lock      = $urandom_range(0, 1) == 1;
`endif
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_mux_nbit
